// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the CPU pipeline.
//   NOP_INSTR          - instruction word placed in IF/ID when it holds no valid op
//   WORD_BYTES         - byte stride between consecutive instruction words
//   DEFAULT_RESET_PC   - default PC after reset
//   DEFAULT_IMEM_WORDS - default instruction memory depth in words
//   ifid_t             - contents of the IF/ID pipeline register
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES         = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam int          DEFAULT_IMEM_WORDS = 32;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with reset > redirect > stall > increment
// priority.
//   clk_i           - rising-edge clock
//   rst_i           - synchronous active-high reset, loads RESET_PC
//   stall_i         - hold the PC
//   redirect_i      - load the redirect target
//   redirect_word_i - redirect target word address (byte address [31:2])
//   pc_o            - current PC (straight from the flop)
//   pc_plus4_o      - PC + 4, wrapping modulo 2^32
module pc_register
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [29:0] redirect_word_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o
);

   logic [31:0] pc_q, pc_d;

   // 32-bit adder, carry out dropped so 0xFFFF_FFFC wraps to 0.
   assign pc_plus4_o = pc_q + WORD_BYTES;

   always_comb begin
      pc_d = pc_q;
      if (redirect_i)
         pc_d = {redirect_word_i, 2'b00};
      else if (!stall_i)
         pc_d = pc_plus4_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Drives the word-addressed instruction memory
// from the PC, latches the returned word into the IF/ID register, flags
// illegal fetch addresses (sticky) and counts delivered instructions.
//   clk_i, rst_i      - clock, synchronous active-high reset
//   stall_i           - hold PC, IF/ID and counter
//   redirect_i        - flush IF/ID and jump to redirect_pc_i
//   redirect_pc_i     - redirect byte target (low bits ignored, misalignment flagged)
//   pc_addr_o         - fetch byte address, registered
//   instr_i           - combinational instruction memory data for pc_addr_o
//   ifid_instr_o      - latched instruction (0 when not valid)
//   ifid_pc_plus4_o   - latched PC+4
//   ifid_valid_o      - IF/ID holds a real instruction
//   fetch_cnt_o       - count of valid instructions delivered (wraps)
//   addr_err_o        - sticky illegal fetch / misaligned redirect flag
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_addr_o,
   input  logic [31:0] instr_i,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_pc_plus4_o,
   output logic        ifid_valid_o,
   output logic [31:0] fetch_cnt_o,
   output logic        addr_err_o
);

   localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

   logic [31:0] pc, pc_plus4;
   logic        in_range;

   ifid_t       ifid_q, ifid_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic        addr_err_q, addr_err_d;

   pc_register #(
      .RESET_PC(RESET_PC)
   ) u_pc (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .stall_i         (stall_i),
      .redirect_i      (redirect_i),
      .redirect_word_i (redirect_pc_i[31:2]),
      .pc_o            (pc),
      .pc_plus4_o      (pc_plus4)
   );

   // Word index compare; the byte offset of the PC is always zero.
   assign in_range = (pc[31:2] < IMEM_LIMIT);

   always_comb begin
      ifid_d      = ifid_q;
      fetch_cnt_d = fetch_cnt_q;
      addr_err_d  = addr_err_q;
      if (redirect_i) begin
         // Whatever was fetched this cycle is on the wrong path: flush it.
         ifid_d = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
         if (redirect_pc_i[1:0] != 2'b00)
            addr_err_d = 1'b1;
      end else if (!stall_i) begin
         if (in_range) begin
            ifid_d      = '{instr: instr_i, pc_plus4: pc_plus4, valid: 1'b1};
            fetch_cnt_d = fetch_cnt_q + 32'd1;
         end else begin
            // Keep pc_plus4 so the PC trail stays visible, but deliver a bubble.
            ifid_d     = '{instr: NOP_INSTR, pc_plus4: pc_plus4, valid: 1'b0};
            addr_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ifid_q      <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
         fetch_cnt_q <= 32'h0;
         addr_err_q  <= 1'b0;
      end else begin
         ifid_q      <= ifid_d;
         fetch_cnt_q <= fetch_cnt_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign pc_addr_o       = pc;
   assign ifid_instr_o    = ifid_q.instr;
   assign ifid_pc_plus4_o = ifid_q.pc_plus4;
   assign ifid_valid_o    = ifid_q.valid;
   assign fetch_cnt_o     = fetch_cnt_q;
   assign addr_err_o      = addr_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam int WORDS = 32;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_i, redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] pc_addr_o, instr_i, ifid_instr_o, ifid_pc_plus4_o, fetch_cnt_o;
   logic        ifid_valid_o, addr_err_o;

   int checks = 0;
   int errors = 0;

   // Instruction memory contents: word i holds 0x1000_0000 + i.
   logic [31:0] mem [WORDS];

   // Reference state of the stage as seen from outside.
   logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
   logic        m_valid, m_err;

   always #5 clk_i = ~clk_i;

   assign instr_i = (pc_addr_o < 32'(WORDS * 4)) ? mem[pc_addr_o[6:2]] : 32'hDEAD_BEEF;

   fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .stall_i         (stall_i),
      .redirect_i      (redirect_i),
      .redirect_pc_i   (redirect_pc_i),
      .pc_addr_o       (pc_addr_o),
      .instr_i         (instr_i),
      .ifid_instr_o    (ifid_instr_o),
      .ifid_pc_plus4_o (ifid_pc_plus4_o),
      .ifid_valid_o    (ifid_valid_o),
      .fetch_cnt_o     (fetch_cnt_o),
      .addr_err_o      (addr_err_o)
   );

   function automatic logic [31:0] word(input int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge with the given inputs, step the reference, then compare.
   task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
      rst_i = r; stall_i = s; redirect_i = rd; redirect_pc_i = rpc;
      @(posedge clk_i);
      if (r) begin
         m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_err = 0;
      end else if (rd) begin
         m_pc = rpc & ~32'h3; m_instr = 0; m_pc4 = 0; m_valid = 0;
         if (rpc % 4 != 0) m_err = 1;
      end else if (!s) begin
         m_pc4 = m_pc + 4;
         if (m_pc / 4 < WORDS) begin
            m_instr = word(int'(m_pc / 4)); m_valid = 1; m_cnt = m_cnt + 1;
         end else begin
            m_instr = 0; m_valid = 0; m_err = 1;
         end
         m_pc = m_pc4;
      end
      #1;
      chk("pc_addr",  pc_addr_o,       m_pc);
      chk("instr",    ifid_instr_o,    m_instr);
      chk("pc_plus4", ifid_pc_plus4_o, m_pc4);
      chk("valid",    32'(ifid_valid_o), 32'(m_valid));
      chk("cnt",      fetch_cnt_o,     m_cnt);
      chk("err",      32'(addr_err_o), 32'(m_err));
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = word(i);
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_err = 0;

      // Reset state
      cycle(1, 0, 0, 0);
      chk("rst_pc", pc_addr_o, 32'h0);
      chk("rst_valid", 32'(ifid_valid_o), 32'h0);

      // Run to pc=8, then stall 3 cycles
      cycle(0, 0, 0, 0);
      chk("run_instr0", ifid_instr_o, word(0));
      cycle(0, 0, 0, 0);
      chk("run_pc8", pc_addr_o, 32'h8);
      chk("run_instr1", ifid_instr_o, word(1));
      for (int k = 0; k < 3; k++) begin
         cycle(0, 1, 0, 0);
         chk("stall_pc", pc_addr_o, 32'h8);
         chk("stall_instr", ifid_instr_o, word(1));
         chk("stall_cnt", fetch_cnt_o, 32'd2);
      end
      cycle(0, 0, 0, 0);
      chk("resume_instr", ifid_instr_o, word(2));
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      chk("cnt5", fetch_cnt_o, 32'd5);

      // Redirect wins over stall
      cycle(0, 1, 1, 32'h14);
      chk("redir_pc", pc_addr_o, 32'h14);
      chk("redir_bubble", 32'(ifid_valid_o), 32'h0);
      cycle(0, 0, 0, 0);
      chk("redir_instr", ifid_instr_o, word(5));
      chk("redir_pc4", ifid_pc_plus4_o, 32'h18);

      // Last legal word then out of range
      cycle(0, 0, 1, 32'h7C);
      cycle(0, 0, 0, 0);
      chk("last_word", ifid_instr_o, word(31));
      chk("last_valid", 32'(ifid_valid_o), 32'h1);
      chk("last_noerr", 32'(addr_err_o), 32'h0);
      cycle(0, 0, 0, 0);
      chk("oor_valid", 32'(ifid_valid_o), 32'h0);
      chk("oor_err", 32'(addr_err_o), 32'h1);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 32'h0);
      chk("err_sticky", 32'(addr_err_o), 32'h1);

      // Misaligned redirect
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 32'h0000_000A);
      chk("mis_pc", pc_addr_o, 32'h8);
      chk("mis_err", 32'(addr_err_o), 32'h1);

      // PC wrap at top of address space
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0);
      chk("wrap_pc", pc_addr_o, 32'h0);
      chk("wrap_pc4", ifid_pc_plus4_o, 32'h0);
      chk("wrap_err", 32'(addr_err_o), 32'h1);

      // Reset during stall with redirect pending
      cycle(1, 0, 0, 0);
      for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      chk("pre_rst_cnt", fetch_cnt_o, 32'd7);
      cycle(1, 1, 1, 32'h40);
      chk("mid_rst_pc", pc_addr_o, 32'h0);
      chk("mid_rst_cnt", fetch_cnt_o, 32'h0);
      chk("mid_rst_instr", ifid_instr_o, 32'h0);

      // Random traffic against the reference
      for (int n = 0; n < 400; n++) begin
         logic r, s, rd;
         logic [31:0] t;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 25);
         rd = ($urandom_range(0, 99) < 10);
         t  = 32'($urandom_range(0, 40)) * 4;
         if ($urandom_range(0, 9) == 0) t = t | 32'($urandom_range(1, 3));
         cycle(r, s, rd, t);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
